// File: rtl/transaction_control.sv
// Sequences one key-checked coin transfer between P1 and P2 through the shared balance/key memory.
// Latency: three reads of RD_LAT+1 cycles, one check cycle, two write cycles, then the animation wait.
// Backpressure: start_transaction is a level handshake; finished_transaction holds until it drops.
module transaction_control #(
    parameter int BAL_W   = 8,
    parameter int KEY_W   = 4,
    parameter int RD_LAT  = 2,
    parameter int ANIM_TO = 4095
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start_transaction,
    input  logic             player,
    input  logic [BAL_W-1:0] amount,
    input  logic [KEY_W-1:0] key,
    input  logic [BAL_W-1:0] mem_rdata,
    input  logic             anim_done,
    output logic [1:0]       mem_addr,
    output logic [BAL_W-1:0] mem_wdata,
    output logic             mem_wren,
    output logic             anim_start,
    output logic             finished_transaction,
    output logic [1:0]       status,
    output logic [3:0]       state_o
);
    localparam int RC_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
    localparam int TO_W = (ANIM_TO > 1) ? $clog2(ANIM_TO + 1) : 1;
    localparam logic [RC_W-1:0] RD_LAST = RC_W'(RD_LAT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((ANIM_TO > 0) ? ANIM_TO - 1 : 0);

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_BAD_KEY  = 2'b01;
    localparam logic [1:0] ST_NO_FUNDS = 2'b10;
    localparam logic [1:0] ST_OVERFLOW = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_RD_KEY = 4'd1,
        S_RD_SRC = 4'd2,
        S_RD_DST = 4'd3,
        S_CHK    = 4'd4,
        S_WR_SRC = 4'd5,
        S_WR_DST = 4'd6,
        S_ANIM   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    typedef struct packed {
        logic             player;
        logic [BAL_W-1:0] amount;
        logic [KEY_W-1:0] key;
    } req_t;

    state_t           state, state_nxt;
    req_t             req;
    logic [BAL_W-1:0] src_bal, dst_bal;
    logic [KEY_W-1:0] key_mem;
    logic [1:0]       status_q, status_nxt;
    logic [RC_W-1:0]  rd_cnt;
    logic [TO_W-1:0]  anim_cnt;
    logic             latch_req;
    logic             is_rd, rd_last, anim_timeout;
    logic [BAL_W:0]   dst_sum;

    assign is_rd        = (state == S_RD_KEY) || (state == S_RD_SRC) || (state == S_RD_DST);
    assign rd_last      = (rd_cnt == RD_LAST);
    assign dst_sum      = {1'b0, dst_bal} + {1'b0, req.amount};
    assign anim_timeout = (ANIM_TO != 0) && (anim_cnt == TO_LAST);

    always_comb begin
        state_nxt  = state;
        status_nxt = status_q;
        latch_req  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_transaction) begin
                    latch_req  = 1'b1;
                    status_nxt = ST_OK;
                    state_nxt  = S_RD_KEY;
                end
            end
            S_RD_KEY: begin
                if (!start_transaction) state_nxt = S_IDLE;
                else if (rd_last)       state_nxt = S_RD_SRC;
            end
            S_RD_SRC: begin
                if (!start_transaction) state_nxt = S_IDLE;
                else if (rd_last)       state_nxt = S_RD_DST;
            end
            S_RD_DST: begin
                if (!start_transaction) state_nxt = S_IDLE;
                else if (rd_last)       state_nxt = S_CHK;
            end
            S_CHK: begin
                if (!start_transaction) begin
                    state_nxt = S_IDLE;
                end else if (key_mem != req.key) begin
                    status_nxt = ST_BAD_KEY;
                    state_nxt  = S_DONE;
                end else if (src_bal < req.amount) begin
                    status_nxt = ST_NO_FUNDS;
                    state_nxt  = S_DONE;
                end else if (dst_sum[BAL_W]) begin
                    status_nxt = ST_OVERFLOW;
                    state_nxt  = S_DONE;
                end else begin
                    state_nxt = S_WR_SRC;
                end
            end
            // The write pair is atomic: once the debit lands, the credit always follows.
            S_WR_SRC: state_nxt = S_WR_DST;
            S_WR_DST: state_nxt = start_transaction ? S_ANIM : S_DONE;
            S_ANIM: begin
                if (anim_done || anim_timeout) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (!start_transaction) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = 2'b00;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        case (state)
            S_RD_KEY: mem_addr = {1'b1, req.player};
            S_RD_SRC: mem_addr = {1'b0, req.player};
            S_RD_DST: mem_addr = {1'b0, ~req.player};
            S_WR_SRC: begin
                mem_addr  = {1'b0, req.player};
                mem_wdata = src_bal - req.amount;
                mem_wren  = 1'b1;
            end
            S_WR_DST: begin
                mem_addr  = {1'b0, ~req.player};
                mem_wdata = dst_sum[BAL_W-1:0];
                mem_wren  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            req      <= '0;
            src_bal  <= '0;
            dst_bal  <= '0;
            key_mem  <= '0;
            status_q <= ST_OK;
            rd_cnt   <= '0;
            anim_cnt <= '0;
        end else begin
            state    <= state_nxt;
            status_q <= status_nxt;
            if (latch_req) begin
                req <= '{player: player, amount: amount, key: key};
            end
            rd_cnt <= (is_rd && !rd_last) ? rd_cnt + 1'b1 : '0;
            // Read data is valid only on the last address-hold cycle.
            if (is_rd && rd_last) begin
                case (state)
                    S_RD_KEY: key_mem <= mem_rdata[KEY_W-1:0];
                    S_RD_SRC: src_bal <= mem_rdata;
                    S_RD_DST: dst_bal <= mem_rdata;
                    default: ;
                endcase
            end
            // Saturating so anim_start cannot re-fire while waiting forever.
            if (state == S_ANIM) begin
                if (anim_cnt != '1) anim_cnt <= anim_cnt + 1'b1;
            end else begin
                anim_cnt <= '0;
            end
        end
    end

    assign anim_start           = (state == S_ANIM) && (anim_cnt == '0);
    assign finished_transaction = (state == S_DONE);
    assign status               = status_q;
    assign state_o              = state;

endmodule

// File: tb/tb_transaction_control.sv
// Drives two instances (read latency 1 and 3) with directed and random transfers against
// a memory model and a rule-level transfer model; outputs sampled on the falling edge.
module tb_transaction_control;
    localparam int BAL_W   = 8;
    localparam int KEY_W   = 4;
    localparam int ANIM_TO = 16;
    localparam int NI      = 2;

    logic             clock = 1'b0;
    logic             resetn;
    logic             player;
    logic [BAL_W-1:0] amount;
    logic [KEY_W-1:0] key;
    logic             start_transaction    [NI];
    logic             anim_done            [NI];
    logic [BAL_W-1:0] mem_rdata            [NI];
    logic [1:0]       mem_addr             [NI];
    logic [BAL_W-1:0] mem_wdata            [NI];
    logic             mem_wren             [NI];
    logic             anim_start           [NI];
    logic             finished_transaction [NI];
    logic [1:0]       status               [NI];
    logic [3:0]       state_o              [NI];

    int mem  [NI][4];
    int pipe [NI][4];
    int wr_inst[$];
    int wr_addr[$];
    int wr_data[$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        transaction_control #(
            .BAL_W  (BAL_W),
            .KEY_W  (KEY_W),
            .RD_LAT (g == 0 ? 1 : 3),
            .ANIM_TO(ANIM_TO)
        ) u_dut (
            .clock               (clock),
            .resetn              (resetn),
            .start_transaction   (start_transaction[g]),
            .player              (player),
            .amount              (amount),
            .key                 (key),
            .mem_rdata           (mem_rdata[g]),
            .anim_done           (anim_done[g]),
            .mem_addr            (mem_addr[g]),
            .mem_wdata           (mem_wdata[g]),
            .mem_wren            (mem_wren[g]),
            .anim_start          (anim_start[g]),
            .finished_transaction(finished_transaction[g]),
            .status              (status[g]),
            .state_o             (state_o[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a falling edge; applies this cycle's writes, shifts the read pipe, returns at the next falling edge.
    task automatic advance();
        for (int i = 0; i < NI; i++) begin
            if (mem_wren[i]) begin
                mem[i][mem_addr[i]] = int'(mem_wdata[i]);
                wr_inst.push_back(i);
                wr_addr.push_back(int'(mem_addr[i]));
                wr_data.push_back(int'(mem_wdata[i]));
            end
            for (int s = 3; s > 0; s--) pipe[i][s] = pipe[i][s-1];
            pipe[i][0] = int'(mem_addr[i]);
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < NI; i++) mem_rdata[i] = BAL_W'(mem[i][pipe[i][lat_of(i)-1]]);
        @(negedge clock);
    endtask

    function automatic void ref_xfer(input int i, input int p, input int amt, input int k,
                                     output int st, output int nsrc, output int ndst);
        int src, dst, kv;
        src  = mem[i][p];
        dst  = mem[i][1-p];
        kv   = mem[i][2+p] % (1 << KEY_W);
        nsrc = src;
        ndst = dst;
        if (k != kv)                            st = 1;
        else if (src < amt)                     st = 2;
        else if (dst + amt > (1 << BAL_W) - 1)  st = 3;
        else begin
            st   = 0;
            nsrc = src - amt;
            ndst = dst + amt;
        end
    endfunction

    // mode: 0 normal, 1 drop start while reading the sender balance, 2 drop start on the first write.
    // dly: cycles from anim_start to an anim_done pulse, negative = never (timeout).
    task automatic run_txn(input int i, input int b0, input int b1, input int k0, input int k1,
                           input int p, input int amt, input int k, input int mode, input int dly);
        int st, nsrc, ndst, n_anim, t, t_anim, t_fin, t_drop, wr0, n_wr, exp_wr, exp_anim;
        bit seen_key, dropped;
        mem[i][0] = b0;
        mem[i][1] = b1;
        mem[i][2] = k0;
        mem[i][3] = k1;
        ref_xfer(i, p, amt, k, st, nsrc, ndst);
        wr0      = wr_inst.size();
        n_anim   = 0;
        t_anim   = -1;
        t_fin    = -1;
        t_drop   = -100;
        seen_key = 1'b0;
        dropped  = 1'b0;
        player   = p[0];
        amount   = BAL_W'(amt);
        key      = KEY_W'(k);
        start_transaction[i] = 1'b1;
        for (t = 0; t < 200; t++) begin
            if (anim_start[i]) begin
                n_anim++;
                t_anim = t;
            end
            anim_done[i] = (t_anim >= 0 && dly >= 0 && t == t_anim + dly);
            if (mem_addr[i] >= 2'd2) seen_key = 1'b1;
            if (dropped && state_o[i] == 4'd0) break;
            if (finished_transaction[i]) begin
                t_fin = t;
                break;
            end
            if (!dropped && ((mode == 1 && seen_key && int'(mem_addr[i]) == p) ||
                             (mode == 2 && mem_wren[i]))) begin
                start_transaction[i] = 1'b0;
                dropped = 1'b1;
                t_drop  = t;
            end
            if (t == 1) begin
                player = 1'($urandom);
                amount = BAL_W'($urandom);
                key    = KEY_W'($urandom);
            end
            advance();
        end
        anim_done[i] = 1'b0;
        if (t >= 200) begin
            chk("txn_timeout", 0, 1);
            start_transaction[i] = 1'b0;
        end

        exp_wr   = (st == 0 && mode != 1) ? 2 : 0;
        exp_anim = (st == 0 && mode == 0) ? 1 : 0;
        if (mode == 1) begin
            chk("abort_to_idle_cycles", t - t_drop, 1);
            chk("abort_status", int'(status[i]), 0);
        end else begin
            chk("status", int'(status[i]), st);
        end
        n_wr = wr_inst.size() - wr0;
        chk("write_count", n_wr, exp_wr);
        if (exp_wr == 2 && n_wr == 2) begin
            chk("wr_src_inst", wr_inst[wr0], i);
            chk("wr_src_addr", wr_addr[wr0], p);
            chk("wr_src_data", wr_data[wr0], nsrc);
            chk("wr_dst_inst", wr_inst[wr0+1], i);
            chk("wr_dst_addr", wr_addr[wr0+1], 1 - p);
            chk("wr_dst_data", wr_data[wr0+1], ndst);
        end
        chk("anim_pulses", n_anim, exp_anim);
        if (exp_anim == 1 && t_anim >= 0 && t_fin >= 0)
            chk("anim_to_done", t_fin - t_anim, (dly < 0) ? ANIM_TO : dly + 1);

        if (!dropped) begin
            for (int h = 0; h < 2; h++) begin
                advance();
                chk("finished_hold", int'(finished_transaction[i]), 1);
            end
            start_transaction[i] = 1'b0;
        end
        advance();
        chk("idle_state", int'(state_o[i]), 0);
        chk("idle_finished", int'(finished_transaction[i]), 0);
        chk("idle_addr", int'(mem_addr[i]), 0);
    endtask

    initial begin
        int b0, b1, k0, k1, p, src, k, amt, r, mode, dly;
        resetn = 1'b0;
        player = 1'b0;
        amount = '0;
        key    = '0;
        for (int i = 0; i < NI; i++) begin
            start_transaction[i] = 1'b0;
            anim_done[i]         = 1'b0;
            mem_rdata[i]         = '0;
            for (int a = 0; a < 4; a++) begin
                mem[i][a]  = 0;
                pipe[i][a] = 0;
            end
        end
        repeat (3) @(negedge clock);
        for (int i = 0; i < NI; i++) begin
            chk("rst_state", int'(state_o[i]), 0);
            chk("rst_wren", int'(mem_wren[i]), 0);
            chk("rst_anim", int'(anim_start[i]), 0);
            chk("rst_finished", int'(finished_transaction[i]), 0);
            chk("rst_status", int'(status[i]), 0);
            chk("rst_addr", int'(mem_addr[i]), 0);
            chk("rst_wdata", int'(mem_wdata[i]), 0);
        end
        resetn = 1'b1;
        advance();

        for (int i = 0; i < NI; i++) begin
            run_txn(i, 100, 50, 5, 9, 0, 30, 5, 0, 2);
            run_txn(i, 100, 50, 5, 9, 0, 30, 6, 0, 2);
            run_txn(i, 100, 50, 5, 9, 1, 51, 9, 0, 1);
            run_txn(i, 70, 50, 5, 9, 1, 50, 9, 0, 0);
            run_txn(i, 10, 250, 5, 9, 0, 10, 5, 0, 3);
            run_txn(i, 100, 50, 5, 9, 0, 30, 5, 1, 0);
            run_txn(i, 100, 50, 5, 9, 0, 30, 5, 2, 0);
            run_txn(i, 100, 50, 5, 9, 0, 30, 5, 0, -1);
            run_txn(i, 100, 50, 5, 9, 1, 0, 9, 0, 0);
            run_txn(i, 100, 50, 165, 9, 0, 100, 5, 0, 4);

            for (int n = 0; n < 40; n++) begin
                b0  = $urandom_range(0, 255);
                b1  = $urandom_range(0, 255);
                k0  = $urandom_range(0, 255);
                k1  = $urandom_range(0, 255);
                p   = $urandom_range(0, 1);
                src = (p == 1) ? b1 : b0;
                k   = ($urandom_range(0, 3) != 0) ? (((p == 1) ? k1 : k0) % 16) : $urandom_range(0, 15);
                amt = ($urandom_range(0, 1) == 1) ? $urandom_range(0, (src + 8 > 255) ? 255 : src + 8)
                                                  : $urandom_range(0, 255);
                r    = $urandom_range(0, 9);
                mode = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
                dly  = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 5);
                run_txn(i, b0, b1, k0, k1, p, amt, k, mode, dly);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
